rf_writeback_ctrl: RTL
======================

// Module: rf_writeback_ctrl
// PURPOSE
//  Write-side front end for the 64-bit, 32-entry register file. Collects results from two
//  producers (single-cycle ALU, variable-latency load unit), buffers each in a small FIFO,
//  and arbitrates them onto the file's single write port (rd / WriteData / RegWrite).
//  Also exports a pending-destination mask that the hazard logic uses to stall readers.
// PARAMETERS
//  XLEN     64  data width of a write-back result
//  DEPTH    2   entries per producer FIFO (power of 2, >=2)
//  CNT_W    32  width of the write statistics counter
// PORTS
//  clk         in   1     clock
//  reset       in   1     synchronous, active-high reset
//  alu_valid   in   1     ALU result offered
//  alu_rd      in   5     ALU destination register
//  alu_data    in   XLEN  ALU result
//  alu_ready   out  1     ALU FIFO can accept
//  ld_valid    in   1     load result offered
//  ld_rd       in   5     load destination register
//  ld_data     in   XLEN  load result
//  ld_ready    out  1     load FIFO can accept
//  rf_we       out  1     to register-file RegWrite
//  rf_rd       out  5     to register-file rd
//  rf_wdata    out  XLEN  to register-file WriteData
//  pend_mask   out  32    bit r=1: a write to xr is queued or on the write port
//  wb_count    out  CNT_W number of writes issued (rf_we pulses) since reset
// BEHAVIOUR
//  - Reset (sync): both FIFOs empty, rf_we=0, rf_rd=0, rf_wdata=0, pend_mask=0, wb_count=0,
//    last_grant=LD (so ALU wins first tie). Reset mid-operation drops all queued entries.
//  - Accept: entry pushed at posedge when valid&&ready. ready = !full (registered-state
//    based; no same-cycle pass-through, no push into a full FIFO even if it pops that edge).
//  - Arbitration each cycle on FIFO heads: one non-empty -> grant it; both non-empty ->
//    grant the source != last_grant, then update last_grant; none -> rf_we=0 next cycle.
//  - Granted head popped at the posedge; same edge loads rf_rd/rf_wdata and sets
//    rf_we = (rd != 0). Latency: entry accepted at edge k drives rf_* during cycle after k+1
//    (earliest); the register file commits it at edge k+2.
//  - rd==0: entry popped and discarded; rf_we stays 0, wb_count unchanged.
//  - wb_count increments by 1 for each cycle rf_we=1; wraps modulo 2^CNT_W.
//  - pend_mask: combinational OR over valid entries of both FIFOs plus the output register
//    when rf_we=1; bit 0 forced 0. A bit clears in the cycle after its write commits.
//  - Order preserved per source; no ordering between sources. Producers must not issue a
//    second write to an rd whose pend_mask bit is set (bench asserts this).
//  - Register file always accepts; no backpressure on the write port.
// STRUCTURE
//  - Shared package rv_pkg: XLEN=64, REG_ADDR_W=5, NUM_REGS=32,
//    typedef struct packed {logic [4:0] rd; logic [XLEN-1:0] data;} wb_entry_t,
//    typedef enum logic {SRC_ALU, SRC_LD} wb_src_t.
//  - One sub-module wb_fifo (DEPTH-entry wb_entry_t FIFO: push/pop/full/empty/head,
//    per-entry valid vector for pend_mask), instantiated for ALU and load paths.
//  - Top holds arbiter, last_grant flop, output register, counter, pend_mask OR tree.
// TESTING
//  1 Reset held 2 cycles -> rf_we=0, alu_ready=ld_ready=1, pend_mask=0, wb_count=0.
//  2 ALU push rd=5 data=0x2A at edge k -> rf_we=1,rf_rd=5,rf_wdata=0x2A after k+1;
//    pend_mask[5]=1 after k through k+2, 0 after k+2; wb_count=1.
//  3 Same-cycle ALU(rd=1,0x11)+LD(rd=2,0x22) -> writes rd=1 then rd=2 on consecutive
//    cycles; next tie grants LD first after an ALU grant.
//  4 ALU push rd=0 data=0xFF -> rf_we never 1, wb_count unchanged, pend_mask stays 0.
//  5 Both push every cycle for 8 cycles, DEPTH=2 -> ready deasserts when full, grants
//    alternate ALU/LD, every accepted entry written once, per-source order kept.
//  6 3 entries queued, reset asserted 1 cycle -> no rf_we after reset, pend_mask=0,
//    readies=1; fresh push afterwards completes normally.

Source files
------------

// File: rtl/rv_pkg.sv
// Shared register-file write-back types: result entry, producer id and a one-hot decoder.
package rv_pkg;

  localparam int XLEN       = 64;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
  } wb_entry_t;

  typedef enum logic {SRC_ALU, SRC_LD} wb_src_t;

  function automatic logic [NUM_REGS-1:0] rd_onehot(input logic [REG_ADDR_W-1:0] rd);
    logic [NUM_REGS-1:0] v;
    v     = '0;
    v[rd] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// DEPTH-entry write-back result FIFO; head visible the cycle after push, no bypass.
// Exposes per-slot valid bits and slot contents so the owner can see every queued rd.
module wb_fifo
  import rv_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_push,
  input  wb_entry_t             i_entry,
  input  logic                  i_pop,
  output logic                  o_full,
  output logic                  o_empty,
  output wb_entry_t             o_head,
  output logic      [DEPTH-1:0] o_entry_vld,
  output wb_entry_t [DEPTH-1:0] o_entries
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  wb_entry_t [DEPTH-1:0] r_mem;
  logic      [DEPTH-1:0] r_vld;
  logic      [PTR_W-1:0] r_wr_ptr;
  logic      [PTR_W-1:0] r_rd_ptr;

  logic w_push;
  logic w_pop;

  assign o_full      = &r_vld;
  assign o_empty     = ~|r_vld;
  assign w_push      = i_push && !o_full;
  assign w_pop       = i_pop && !o_empty;
  assign o_head      = r_mem[r_rd_ptr];
  assign o_entry_vld = r_vld;
  assign o_entries   = r_mem;

  // Guarded push/pop never touch the same slot in one edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_vld    <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= i_entry;
        r_vld[r_wr_ptr] <= 1'b1;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_vld[r_rd_ptr] <= 1'b0;
        r_rd_ptr        <= r_rd_ptr + 1'b1;
      end
    end
  end

endmodule

// File: rtl/rf_writeback_ctrl.sv
// Arbitrates buffered ALU and load results onto the single register-file write port.
// Accept-to-write-port latency 1 cycle minimum; producers stall only on a full FIFO.
module rf_writeback_ctrl
  import rv_pkg::*;
#(
  parameter int XLEN  = 64,
  parameter int DEPTH = 2,
  parameter int CNT_W = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  alu_valid,
  input  logic [REG_ADDR_W-1:0] alu_rd,
  input  logic [XLEN-1:0]       alu_data,
  output logic                  alu_ready,
  input  logic                  ld_valid,
  input  logic [REG_ADDR_W-1:0] ld_rd,
  input  logic [XLEN-1:0]       ld_data,
  output logic                  ld_ready,
  output logic                  rf_we,
  output logic [REG_ADDR_W-1:0] rf_rd,
  output logic [XLEN-1:0]       rf_wdata,
  output logic [NUM_REGS-1:0]   pend_mask,
  output logic [CNT_W-1:0]      wb_count
);

  wb_entry_t             w_alu_in, w_ld_in, w_alu_head, w_ld_head, w_gnt_entry;
  wb_entry_t [DEPTH-1:0] w_alu_entries, w_ld_entries;
  logic      [DEPTH-1:0] w_alu_vld, w_ld_vld;
  logic                  w_alu_full, w_alu_empty, w_ld_full, w_ld_empty;
  logic                  w_gnt_alu, w_gnt_ld, w_tie;
  logic [NUM_REGS-1:0]   w_pend;

  logic                  r_rf_we;
  logic [REG_ADDR_W-1:0] r_rf_rd;
  logic [XLEN-1:0]       r_rf_wdata;
  logic [CNT_W-1:0]      r_wb_count;
  wb_src_t               r_last_grant;

  assign w_alu_in  = '{rd: alu_rd, data: alu_data};
  assign w_ld_in   = '{rd: ld_rd, data: ld_data};
  assign alu_ready = !w_alu_full;
  assign ld_ready  = !w_ld_full;

  wb_fifo #(.DEPTH(DEPTH)) u_alu_fifo (
    .clk         (clk),
    .reset       (reset),
    .i_push      (alu_valid && !w_alu_full),
    .i_entry     (w_alu_in),
    .i_pop       (w_gnt_alu),
    .o_full      (w_alu_full),
    .o_empty     (w_alu_empty),
    .o_head      (w_alu_head),
    .o_entry_vld (w_alu_vld),
    .o_entries   (w_alu_entries)
  );

  wb_fifo #(.DEPTH(DEPTH)) u_ld_fifo (
    .clk         (clk),
    .reset       (reset),
    .i_push      (ld_valid && !w_ld_full),
    .i_entry     (w_ld_in),
    .i_pop       (w_gnt_ld),
    .o_full      (w_ld_full),
    .o_empty     (w_ld_empty),
    .o_head      (w_ld_head),
    .o_entry_vld (w_ld_vld),
    .o_entries   (w_ld_entries)
  );

  // Round-robin pointer only moves on a genuine tie, so a lone grant keeps the tie order.
  assign w_tie       = !w_alu_empty && !w_ld_empty;
  assign w_gnt_alu   = !w_alu_empty && (w_ld_empty || (r_last_grant == SRC_LD));
  assign w_gnt_ld    = !w_ld_empty && !w_gnt_alu;
  assign w_gnt_entry = w_gnt_alu ? w_alu_head : w_ld_head;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rf_we      <= 1'b0;
      r_rf_rd      <= '0;
      r_rf_wdata   <= '0;
      r_wb_count   <= '0;
      r_last_grant <= SRC_LD;
    end else begin
      r_wb_count <= r_wb_count + CNT_W'(r_rf_we);
      if (w_gnt_alu || w_gnt_ld) begin
        r_rf_rd    <= w_gnt_entry.rd;
        r_rf_wdata <= w_gnt_entry.data;
        r_rf_we    <= (w_gnt_entry.rd != '0);
      end else begin
        r_rf_we    <= 1'b0;
      end
      if (w_tie) begin
        r_last_grant <= w_gnt_alu ? SRC_ALU : SRC_LD;
      end
    end
  end

  always_comb begin
    w_pend = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (w_alu_vld[i]) w_pend = w_pend | rd_onehot(w_alu_entries[i].rd);
      if (w_ld_vld[i])  w_pend = w_pend | rd_onehot(w_ld_entries[i].rd);
    end
    if (r_rf_we) w_pend = w_pend | rd_onehot(r_rf_rd);
    w_pend[0] = 1'b0;
  end

  assign rf_we     = r_rf_we;
  assign rf_rd     = r_rf_rd;
  assign rf_wdata  = r_rf_wdata;
  assign pend_mask = w_pend;
  assign wb_count  = r_wb_count;

endmodule
